// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl -- parametrised direct-mapped, write-through cache controller.
//
// Sits between the CPU memory stage and main memory. It services read hits
// from the cache, refills a whole block on a read miss and writes every store
// through to memory. Write hits also update the cached word.
//
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN
//   defined   : a write miss refills the block first and then behaves as a
//               write hit (ack still reports hit=0).
//   undefined : no-write-allocate; a write miss only does the write-through.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   readRequest       CPU read, held with the address until ack
//   writeRequest      CPU write, held with address/data until ack
//   tag/index/offset  CPU word address split into its fields
//   dataFromProg      CPU write data
//   dataOut           read data, valid with ack on a read (held until next read ack)
//   hit, ack          one-cycle completion pulse and its hit indication
//   stall             high while a request is in progress
//   load, loadIndex   block-load request and block address {tag,index}
//   dataFromMain      refill block, word w at [w*DATA_W +: DATA_W]
//   doneLoading       memory strobe: dataFromMain valid this cycle
//   memWrite          write-through request with memAddr/memWriteData
//   memWriteDone      memory accepted the write-through
module dm_cache_ctrl #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 2,
    parameter int OFFSET_W = 1,
    parameter int DATA_W   = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                readRequest,
    input  logic                                writeRequest,
    input  logic [TAG_W-1:0]                    tag,
    input  logic [INDEX_W-1:0]                  index,
    input  logic [OFFSET_W-1:0]                 offset,
    input  logic [DATA_W-1:0]                   dataFromProg,
    output logic [DATA_W-1:0]                   dataOut,
    output logic                                hit,
    output logic                                ack,
    output logic                                stall,
    output logic                                load,
    output logic [TAG_W+INDEX_W-1:0]            loadIndex,
    input  logic [DATA_W*(2**OFFSET_W)-1:0]     dataFromMain,
    input  logic                                doneLoading,
    output logic                                memWrite,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   memAddr,
    output logic [DATA_W-1:0]                   memWriteData,
    input  logic                                memWriteDone
);

    localparam int LINES = 2**INDEX_W;
    localparam int BLK_W = DATA_W*(2**OFFSET_W);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE_THRU} state_t;

    state_t                            state_q, state_d;
    logic                              is_wr_q, is_wr_d;
    logic                              miss_q, miss_d;   // request has missed at least once
    logic                              whit_q, whit_d;   // write hit, reported on ack
    logic [LINES-1:0]                  valid_q, valid_d;
    logic [DATA_W-1:0]                 dout_q, dout_d;
    logic                              hit_q, hit_d;
    logic                              ack_q, ack_d;
    logic                              stall_q, stall_d;
    logic                              load_q, load_d;
    logic [TAG_W+INDEX_W-1:0]          ldidx_q, ldidx_d;
    logic                              mwr_q, mwr_d;
    logic [TAG_W+INDEX_W+OFFSET_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0]                 mwdata_q, mwdata_d;

    logic [TAG_W-1:0]                  tag_q [LINES];
    logic [BLK_W-1:0]                  blk_q [LINES];

    logic                              line_hit;
    logic                              alloc_miss;
    logic                              refill_we;
    logic                              word_we;

    assign line_hit = valid_q[index] && (tag_q[index] == tag);

`ifdef CACHE_WRITE_ALLOCATE_EN
    assign alloc_miss = is_wr_q && !line_hit;
`else
    assign alloc_miss = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        miss_d    = miss_q;
        whit_d    = whit_q;
        valid_d   = valid_q;
        dout_d    = dout_q;
        hit_d     = 1'b0;
        ack_d     = 1'b0;
        stall_d   = stall_q;
        load_d    = load_q;
        ldidx_d   = ldidx_q;
        mwr_d     = mwr_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        refill_we = 1'b0;
        word_we   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // ack_q blocks re-acceptance of a request still held from the last ack
                if (!ack_q && (readRequest || writeRequest)) begin
                    state_d = S_LOOKUP;
                    stall_d = 1'b1;
                    is_wr_d = !readRequest;
                    miss_d  = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (!is_wr_q && line_hit) begin
                    dout_d  = blk_q[index][DATA_W*int'(offset) +: DATA_W];
                    hit_d   = !miss_q;
                    ack_d   = 1'b1;
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end else if (!is_wr_q || alloc_miss) begin
                    load_d  = 1'b1;
                    ldidx_d = {tag, index};
                    miss_d  = 1'b1;
                    state_d = S_REFILL;
                end else begin
                    word_we  = line_hit;
                    whit_d   = line_hit && !miss_q;
                    mwr_d    = 1'b1;
                    maddr_d  = {tag, index, offset};
                    mwdata_d = dataFromProg;
                    state_d  = S_WRITE_THRU;
                end
            end
            S_REFILL: begin
                if (doneLoading) begin
                    refill_we      = 1'b1;
                    valid_d[index] = 1'b1;
                    load_d         = 1'b0;
                    state_d        = S_LOOKUP;
                end
            end
            S_WRITE_THRU: begin
                if (memWriteDone) begin
                    mwr_d   = 1'b0;
                    ack_d   = 1'b1;
                    hit_d   = whit_q;
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            is_wr_q  <= 1'b0;
            miss_q   <= 1'b0;
            whit_q   <= 1'b0;
            valid_q  <= '0;
            dout_q   <= '0;
            hit_q    <= 1'b0;
            ack_q    <= 1'b0;
            stall_q  <= 1'b0;
            load_q   <= 1'b0;
            ldidx_q  <= '0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            is_wr_q  <= is_wr_d;
            miss_q   <= miss_d;
            whit_q   <= whit_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
            hit_q    <= hit_d;
            ack_q    <= ack_d;
            stall_q  <= stall_d;
            load_q   <= load_d;
            ldidx_q  <= ldidx_d;
            mwr_q    <= mwr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Tag/data arrays carry no reset; gating with reset keeps an abandoned
    // refill or write from touching the cache on the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (refill_we) begin
                tag_q[index] <= tag;
                blk_q[index] <= dataFromMain;
            end else if (word_we) begin
                blk_q[index][DATA_W*int'(offset) +: DATA_W] <= dataFromProg;
            end
        end
    end

    assign dataOut      = dout_q;
    assign hit          = hit_q;
    assign ack          = ack_q;
    assign stall        = stall_q;
    assign load         = load_q;
    assign loadIndex    = ldidx_q;
    assign memWrite     = mwr_q;
    assign memAddr      = maddr_q;
    assign memWriteData = mwdata_q;

endmodule
